// File: rtl/mem_responder_pkg.sv
// Shared types for the CPU-side memory responder: FSM states, latched request payload, base address.
// Helpers for byte-lane masking and request legality live here so every user agrees on them.
package rv32i_types;

    localparam logic [31:0] MEM_BASE_ADDR = 32'h1eceb000;
    localparam int unsigned MEM_DATA_W    = 32;
    localparam int unsigned MEM_MASK_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    // Expand a 4-bit byte-enable into a 32-bit lane mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    // A request that both reads and writes, or is not word aligned, is answered with err.
    function automatic logic req_illegal(input mem_req_t r);
        return ((r.rmask != 4'h0) && (r.wmask != 4'h0)) || (r.addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/mem_responder_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) used to randomise per-request latency.
// Advances every cycle; reset seed is 8'hA5.
module mem_resp_lfsr (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] value
);

    logic feedback;

    assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= 8'hA5;
        end else begin
            value <= {value[6:0], feedback};
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: latches a request, waits a latency, then pulses resp with masked data.
// Define MEM_RESPONDER_RAND_LAT_EN to replace the fixed LATENCY with an LFSR-drawn 1..8 cycle latency.
module mem_responder
    import rv32i_types::*;
#(
    parameter logic [31:0] BASE_ADDR  = MEM_BASE_ADDR,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [3:0]  rmask,
    input  logic [3:0]  wmask,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        resp,
    output logic        err
);

    localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;
    localparam int unsigned LAT_BIT = $clog2(LATENCY + 1);
    localparam int unsigned CNT_W   = (LAT_BIT > 4) ? LAT_BIT : 4;

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_WAIT = 2'(WAIT);
    localparam logic [1:0] ST_RESP = 2'(RESP);

    logic [1:0]            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    logic [CNT_W-1:0]      lat_m1;
    mem_req_t              req_q, req_d, in_req, cur;
    logic                  enter_resp;
    logic                  ill;
    logic                  resp_d, err_d;
    logic [31:0]           rdata_d;
    logic                  we;
    logic [DEPTH_LOG2-1:0] idx;

    logic [31:0] mem [DEPTH];

    // Byte address to word index, wrapping modulo the array depth.
    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [31:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 2);
    endfunction

`ifdef MEM_RESPONDER_RAND_LAT_EN
    logic [7:0] lfsr_val;

    mem_resp_lfsr u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .value (lfsr_val)
    );

    assign lat_m1 = CNT_W'(lfsr_val & 8'h07);
`else
    assign lat_m1 = CNT_W'(LATENCY - 1);
`endif

    always_comb begin
        in_req.addr  = addr;
        in_req.rmask = rmask;
        in_req.wmask = wmask;
        in_req.wdata = wdata;
    end

    // Next-state, request latch and registered-output values.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        req_d      = req_q;
        cur        = req_q;
        enter_resp = 1'b0;
        resp_d     = 1'b0;
        err_d      = 1'b0;
        rdata_d    = 32'h0;
        we         = 1'b0;
        ill        = 1'b0;
        idx        = '0;

        case (state)
            ST_IDLE: begin
                if ((rmask | wmask) != 4'h0) begin
                    req_d = in_req;
                    cur   = in_req;
                    cnt_d = lat_m1;
                    if (lat_m1 == '0) begin
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The array is read and written on the edge that enters RESP.
        if (enter_resp) begin
            state_d = ST_RESP;
            ill     = req_illegal(cur);
            idx     = word_idx(cur.addr);
            resp_d  = 1'b1;
            err_d   = ill;
            we      = !ill && (cur.wmask != 4'h0);
            if (!ill && (cur.wmask == 4'h0)) begin
                rdata_d = mem[idx] & lane_mask(cur.rmask);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            req_q <= '0;
            resp  <= 1'b0;
            err   <= 1'b0;
            rdata <= 32'h0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            req_q <= req_d;
            resp  <= resp_d;
            err   <= err_d;
            rdata <= rdata_d;
        end
    end

    // Array contents are intentionally not reset; a write racing reset is dropped.
    always_ff @(posedge clk) begin
        if (!rst && we) begin
            for (int b = 0; b < 4; b++) begin
                if (cur.wmask[b]) begin
                    mem[idx][8*b +: 8] <= cur.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed cases plus randomized traffic against a word-array model.
// Honors MEM_RESPONDER_RAND_LAT_EN by accepting any 1..8 cycle latency.
module tb_mem_responder;

    localparam logic [31:0] BASE = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp;
    logic        err;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model[int unsigned];
    int unsigned written[$];

    mem_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_LOG2 (10),
        .LATENCY    (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .rmask (rmask),
        .wmask (wmask),
        .wdata (wdata),
        .rdata (rdata),
        .resp  (resp),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic int unsigned midx(input logic [31:0] a);
        return ((a - BASE) >> 2) % 1024;
    endfunction

    // Monitor: every resp pulse must match the oldest outstanding expectation.
    exp_t        mon_e;
    int unsigned mon_lat;
    always @(negedge clk) begin
        if (!rst && resp) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_resp: got resp=1 at cycle %0d, required no outstanding request", cyc);
            end else begin
                mon_e   = sbq.pop_front();
                mon_lat = cyc - mon_e.cyc;
                check("rdata", rdata, mon_e.rdata);
                check("err", 32'(err), 32'(mon_e.err));
`ifdef MEM_RESPONDER_RAND_LAT_EN
                tests++;
                if (mon_lat < 1 || mon_lat > 8) begin
                    fails++;
                    $display("FAIL latency: got %0d, required 1..8", mon_lat);
                end
`else
                check("latency", 32'(mon_lat), 32'd2);
`endif
            end
        end
    end

    // Issue one request in an IDLE cycle, record its expected response, then wait for resp.
    task automatic issue(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                         input logic [31:0] wd);
        exp_t        e;
        logic [31:0] w;
        int unsigned i;
        bit          ill;
        bit          seen;
        @(posedge clk);
        #1;
        ill = ((rm != 0) && (wm != 0)) || (a % 4 != 0);
        i   = midx(a);
        e.rdata = 32'h0;
        e.err   = ill;
        e.cyc   = cyc;
        if (!ill && wm != 0) begin
            w = model.exists(i) ? model[i] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (wm[b]) w[8*b +: 8] = wd[8*b +: 8];
            model[i] = w;
            written.push_back(i);
        end else if (!ill) begin
            w = model[i];
            for (int b = 0; b < 4; b++)
                if (rm[b]) e.rdata[8*b +: 8] = w[8*b +: 8];
        end
        sbq.push_back(e);
        addr = a; rmask = rm; wmask = wm; wdata = wd;
        @(posedge clk);
        #1;
        rmask = 4'h0; wmask = 4'h0; wdata = $urandom; addr = $urandom;
        seen = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            @(negedge clk);
            if (resp) seen = 1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL resp_timeout: got no resp within 12 cycles, required one for addr %h", a);
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  m;
        int unsigned kind;

        rst = 1'b1; addr = 32'h0; rmask = 4'h0; wmask = 4'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp", 32'(resp), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_rdata", rdata, 32'h0);
        rst = 1'b0;

        // Basic write/read and byte masks
        issue(32'h1eceb004, 4'h0, 4'hF, 32'hDEADBEEF);
        issue(32'h1eceb004, 4'hF, 4'h0, 32'h0);
        issue(32'h1eceb004, 4'h0, 4'b0101, 32'h11223344);
        issue(32'h1eceb004, 4'b1100, 4'h0, 32'h0);
        // Illegal requests leave the word untouched
        issue(32'h1eceb008, 4'h0, 4'hF, 32'hCAFEF00D);
        issue(32'h1eceb008, 4'hF, 4'hF, 32'h12345678);
        issue(32'h1eceb008, 4'hF, 4'h0, 32'h0);
        issue(32'h1eceb002, 4'hF, 4'h0, 32'h0);
        issue(32'h1eceb002, 4'h0, 4'hF, 32'h55555555);
        issue(32'h1eceb000, 4'hF, 4'h0, 32'h0);
        // Wrap-around: BASE+0x1000 aliases word 0
        issue(BASE + 32'h1000, 4'h0, 4'hF, 32'hA5A5C3C3);
        issue(BASE, 4'hF, 4'h0, 32'h0);

`ifndef MEM_RESPONDER_RAND_LAT_EN
        // Reset during WAIT of a write discards it
        issue(BASE + 32'h10, 4'h0, 4'hF, 32'h01020304);
        @(posedge clk);
        #1;
        addr = BASE + 32'h10; wmask = 4'hF; wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        wmask = 4'h0;
        rst = 1'b1;
        #1;
        check("rst_mid_resp", 32'(resp), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_no_resp", 32'(resp), 32'h0);
        end
        issue(BASE + 32'h10, 4'hF, 4'h0, 32'h0);
`endif

        // Randomized traffic
        for (int n = 0; n < 100; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 2 || (kind <= 7 && written.size() == 0)) begin
                a = BASE + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(0, 3) * 4096);
                m = 4'($urandom_range(1, 15));
                issue(a, 4'h0, m, $urandom);
            end else if (kind <= 7) begin
                a = BASE + 32'(written[$urandom_range(0, written.size() - 1)] * 4)
                    + 32'($urandom_range(0, 3) * 4096);
                m = 4'($urandom_range(1, 15));
                issue(a, m, 4'h0, 32'h0);
            end else if (kind == 8) begin
                a = BASE + 32'($urandom_range(0, 1023) * 4);
                issue(a, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), $urandom);
            end else begin
                a = BASE + 32'($urandom_range(0, 1023) * 4) + 32'($urandom_range(1, 3));
                if ($urandom_range(0, 1) == 0)
                    issue(a, 4'($urandom_range(1, 15)), 4'h0, 32'h0);
                else
                    issue(a, 4'h0, 4'($urandom_range(1, 15)), $urandom);
            end
        end

        repeat (12) @(negedge clk);
        check("outstanding", 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
